// File: rtl/adc_pkg.sv
// Shared definitions for the ADC0820 capture blocks.
package adc_pkg;

  localparam int unsigned ADC_DW          = 8;
  localparam int unsigned VREF_MV_DEFAULT = 5000;

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StCapture,
    StAverage,
    StScale
  } adc_state_e;

endpackage

// File: rtl/adc_sample_averager_if.sv
// ADC0820 pin-level bus: WR_n from the control block, INT_n and DB from the converter.
interface adc_sample_averager_if;
  import adc_pkg::*;

  logic              wr_n;
  logic              int_n;
  logic [ADC_DW-1:0] db;

  // Driving side (control block plus converter model).
  modport master (output wr_n, output int_n, output db);
  // Observing side (the averager).
  modport slave  (input wr_n, input int_n, input db);

endinterface

// File: rtl/adc_edge_sync.sv
// Two-flop synchroniser for an active-low asynchronous pin plus a delay stage;
// fall_o pulses for one cycle when the synchronised level goes high-to-low.
module adc_edge_sync (
  input  logic clk_i,
  input  logic reset_ni,  // synchronous, active-low
  input  logic async_n_i,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  // Shift the pin through the synchroniser and delay stage.
  always_comb begin
    sync1_d = async_n_i;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  // Stages reset to the inactive (high) level so reset release is not seen as a fall.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign fall_o = dly_q & ~sync2_q;

endmodule

// File: rtl/adc_sample_averager.sv
// ADC0820 sample capture, block averaging and millivolt scaling, with INT_n timeout.
// Optional build macro ADC_PEAK_HOLD_EN adds a peak-hold output.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int unsigned LOG2_AVG = 3,
  parameter int unsigned VREF_MV  = VREF_MV_DEFAULT,
  parameter int unsigned MV_W     = 13,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  adc_sample_averager_if.slave  adc,
  input  logic                  err_clr,
  output logic [ADC_DW-1:0]     sample,
  output logic                  sample_valid,
  output logic [ADC_DW-1:0]     avg,
  output logic [MV_W-1:0]       mv,
  output logic                  mv_valid,
`ifdef ADC_PEAK_HOLD_EN
  output logic [ADC_DW-1:0]     peak,
`endif
  output logic                  timeout_err
);

  localparam int unsigned NumAvg = 1 << LOG2_AVG;
  localparam int unsigned AccW   = ADC_DW + LOG2_AVG;
  localparam int unsigned CntW   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned TmoW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned ProdW  = ADC_DW + 32;

  logic int_fall;
  logic wr_rise;

  adc_edge_sync u_int_sync (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .async_n_i (adc.int_n),
    .fall_o    (int_fall)
  );

  adc_state_e        state_q, state_d;
  logic              wr_q, wr_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [ADC_DW-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic [ADC_DW-1:0] avg_q, avg_d;
  logic [MV_W-1:0]   mv_q, mv_d;
  logic              mv_valid_q, mv_valid_d;
  logic              timeout_err_q, timeout_err_d;
`ifdef ADC_PEAK_HOLD_EN
  logic [ADC_DW-1:0] peak_q, peak_d;
`endif

  // wr_n is generated on-chip, so one register is enough for edge detect.
  assign wr_rise = adc.wr_n & ~wr_q;

  // Next-state and registered-output logic for the capture FSM.
  always_comb begin
    state_d        = state_q;
    wr_d           = adc.wr_n;
    tmo_cnt_d      = tmo_cnt_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    avg_d          = avg_q;
    mv_d           = mv_q;
    mv_valid_d     = 1'b0;
    timeout_err_d  = err_clr ? 1'b0 : timeout_err_q;
`ifdef ADC_PEAK_HOLD_EN
    peak_d         = err_clr ? '0 : peak_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (wr_rise) begin
          state_d   = StConvert;
          tmo_cnt_d = '0;
        end
      end
      StConvert: begin
        if (int_fall) begin
          state_d = StCapture;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
          // A new timeout overrides a same-cycle err_clr.
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StCapture: begin
        sample_d       = adc.db;
        sample_valid_d = 1'b1;
        acc_d          = acc_q + AccW'(adc.db);
        cnt_d          = cnt_q + 1'b1;
`ifdef ADC_PEAK_HOLD_EN
        // err_clr restarts the peak from the value captured in the same cycle.
        if (err_clr || (adc.db > peak_q)) peak_d = adc.db;
`endif
        state_d = (cnt_q == CntW'(NumAvg - 1)) ? StAverage : StIdle;
      end
      StAverage: begin
        avg_d   = acc_q[AccW-1:LOG2_AVG];
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StScale;
      end
      StScale: begin
        mv_d       = MV_W'((ProdW'(avg_q) * ProdW'(VREF_MV)) >> 8);
        mv_valid_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      wr_q           <= 1'b0;
      tmo_cnt_q      <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      avg_q          <= '0;
      mv_q           <= '0;
      mv_valid_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
`ifdef ADC_PEAK_HOLD_EN
      peak_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wr_q           <= wr_d;
      tmo_cnt_q      <= tmo_cnt_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      avg_q          <= avg_d;
      mv_q           <= mv_d;
      mv_valid_q     <= mv_valid_d;
      timeout_err_q  <= timeout_err_d;
`ifdef ADC_PEAK_HOLD_EN
      peak_q         <= peak_d;
`endif
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign avg          = avg_q;
  assign mv           = mv_q;
  assign mv_valid     = mv_valid_q;
  assign timeout_err  = timeout_err_q;
`ifdef ADC_PEAK_HOLD_EN
  assign peak         = peak_q;
`endif

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager (default parameters: 8-sample blocks,
// 5000 mV reference, 64-cycle timeout). Define ADC_PEAK_HOLD_EN to cover peak hold.
module tb_adc_sample_averager;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        err_clr;
  logic [7:0]  sample;
  logic        sample_valid;
  logic [7:0]  avg;
  logic [12:0] mv;
  logic        mv_valid;
  logic        timeout_err;
`ifdef ADC_PEAK_HOLD_EN
  logic [7:0]  peak;
`endif

  adc_sample_averager_if bus ();

  adc_sample_averager dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .adc          (bus),
    .err_clr      (err_clr),
    .sample       (sample),
    .sample_valid (sample_valid),
    .avg          (avg),
    .mv           (mv),
    .mv_valid     (mv_valid),
`ifdef ADC_PEAK_HOLD_EN
    .peak         (peak),
`endif
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int sv_count = 0;
  int mv_count = 0;
  int last_sv_cyc = 0;
  int mv_cyc = 0;
  int mv_avg = 0;
  int mv_mv = 0;
  bit seen_err = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sample_valid) begin
      sv_count    <= sv_count + 1;
      last_sv_cyc <= cyc;
    end
    if (mv_valid) begin
      mv_count <= mv_count + 1;
      mv_cyc   <= cyc;
      mv_avg   <= int'(avg);
      mv_mv    <= int'(mv);
    end
    if (timeout_err) seen_err <= 1'b1;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: plain average of the block and millivolt scaling.
  logic [7:0] blk [8];

  function automatic int model_avg();
    int sum = 0;
    for (int i = 0; i < 8; i++) sum += int'(blk[i]);
    return sum / 8;
  endfunction

  function automatic int model_mv(input int a);
    return (a * 5000) / 256;
  endfunction

  // One WR_n-started conversion that completes with data d.
  task automatic do_conv(input logic [7:0] d);
    int  delay;
    bit  seen;
    delay = $urandom_range(1, 20);
    @(posedge clk); #1 bus.wr_n = 1'b1;
    @(posedge clk); #1 bus.wr_n = 1'b0;
    repeat (delay) @(posedge clk);
    #1 bus.int_n = 1'b0;
    bus.db = d;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    if (!seen) begin
      check("sample_valid_seen", 0, 1);
    end else begin
      check("sample", int'(sample), int'(d));
      @(negedge clk);
      check("sample_valid_width", int'(sample_valid), 0);
    end
    bus.int_n = 1'b1;
    bus.db    = 8'($urandom);
    repeat (6) @(posedge clk);
  endtask

  // Eight conversions from blk[], then the block result and its timing.
  task automatic run_block(input string name, input int exp_avg, input int exp_mv);
    int  mvb;
    bit  seen;
    mvb = mv_count;
    for (int i = 0; i < 8; i++) begin
      do_conv(blk[i]);
      if (i == 6) check({name, "_no_early_mv"}, mv_count, mvb);
    end
    seen = (mv_count != mvb);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (mv_count != mvb);
    end
    check({name, "_mv_valid_count"}, mv_count, mvb + 1);
    check({name, "_avg"}, mv_avg, exp_avg);
    check({name, "_mv"}, mv_mv, exp_mv);
    check({name, "_mv_latency"}, mv_cyc - last_sv_cyc, 2);
  endtask

  typedef struct {
    string name;
    int    base;
    int    step;
    int    exp_avg;
    int    exp_mv;
  } vec_t;

  vec_t vecs [4];

  task automatic load_vec(input int k);
    for (int i = 0; i < 8; i++) blk[i] = 8'(vecs[k].base + vecs[k].step * i);
  endtask

  initial begin
    int svb;
    int mvb;
    int a;

    vecs[0] = '{name: "mid",  base: 8'h80, step: 0, exp_avg: 8'h80, exp_mv: 2500};
    vecs[1] = '{name: "ramp", base: 0,     step: 1, exp_avg: 3,     exp_mv: 58};
    vecs[2] = '{name: "full", base: 8'hFF, step: 0, exp_avg: 8'hFF, exp_mv: 4980};
    vecs[3] = '{name: "q40",  base: 8'h40, step: 0, exp_avg: 8'h40, exp_mv: 1250};

    reset_n   = 1'b0;
    err_clr   = 1'b0;
    bus.wr_n  = 1'b0;
    bus.int_n = 1'b1;
    bus.db    = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    check("rst_sample", int'(sample), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_avg", int'(avg), 0);
    check("rst_mv", int'(mv), 0);
    check("rst_mv_valid", int'(mv_valid), 0);
    check("rst_timeout_err", int'(timeout_err), 0);

    // Table-driven blocks.
    for (int k = 0; k < 3; k++) begin
      load_vec(k);
      run_block(vecs[k].name, vecs[k].exp_avg, vecs[k].exp_mv);
    end

    // INT_n never falls: timeout, no sample.
    svb = sv_count;
    @(posedge clk); #1 bus.wr_n = 1'b1;
    @(posedge clk); #1 bus.wr_n = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("tmo_not_early", int'(timeout_err), 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("tmo_set", int'(timeout_err), 1);
    check("tmo_no_sample", sv_count, svb);

    // Good block after a timeout still averages; flag stays sticky.
    for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
    a = model_avg();
    run_block("after_tmo", a, model_mv(a));
    check("tmo_sticky", int'(timeout_err), 1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", int'(timeout_err), 0);

    // err_clr held through a timeout: the set must still be visible.
    seen_err = 1'b0;
    @(posedge clk); #1 err_clr = 1'b1;
    bus.wr_n = 1'b1;
    @(posedge clk); #1 bus.wr_n = 1'b0;
    repeat (80) @(posedge clk);
    #1 err_clr = 1'b0;
    check("set_wins", int'(seen_err), 1);
    @(negedge clk);
    check("set_then_cleared", int'(timeout_err), 0);

    // Random blocks against the reference model.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
      a = model_avg();
      run_block("rand", a, model_mv(a));
    end

    // Partial block discarded by reset.
    for (int i = 0; i < 5; i++) do_conv(8'($urandom));
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("midrst_sample", int'(sample), 0);
    check("midrst_avg", int'(avg), 0);
    check("midrst_mv", int'(mv), 0);
    mvb = mv_count;
    load_vec(3);
    run_block(vecs[3].name, vecs[3].exp_avg, vecs[3].exp_mv);
    repeat (10) @(posedge clk);
    check("midrst_one_mv_valid", mv_count, mvb + 1);

`ifdef ADC_PEAK_HOLD_EN
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("peak_rst", int'(peak), 0);
    do_conv(8'h10);
    do_conv(8'hC3);
    do_conv(8'h22);
    @(negedge clk);
    check("peak_hold", int'(peak), 8'hC3);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("peak_clr", int'(peak), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Consumes the ADC0820 conversion results produced under the WR-RD standalone-mode control block.
- The control block drives WR_n; this block watches WR_n and the ADC INT_n line and captures DB[7:0] after each conversion.
- Averages 2^LOG2_AVG samples and scales the average to millivolts for the voltmeter display path.
- Also flags conversions that never complete (INT_n timeout).

Parameters:
LOG2_AVG, 3, log2 of the number of samples averaged (range 0..6)
VREF_MV, 5000, ADC full-scale reference in millivolts
MV_W, 13, width of the millivolt output; must hold (255*VREF_MV)>>8
TIMEOUT, 64, clk cycles allowed from WR_n rising edge to INT_n falling edge

Ports:
clk  in  1  system clock, 2.08 MHz nominal
reset_n  in  1  synchronous, active-low reset
wr_n  in  1  ADC WR_n, from the control block; conversion starts on its rising edge
int_n  in  1  ADC INT_n, asynchronous pin; low means conversion done
db  in  8  ADC data bus; RD_n is tied low, so the bus is valid while int_n is low
err_clr  in  1  single-cycle pulse; clears timeout_err
sample  out  8  most recent captured conversion
sample_valid  out  1  one-cycle pulse when sample updates
avg  out  8  most recent block average
mv  out  MV_W  avg scaled to millivolts
mv_valid  out  1  one-cycle pulse when avg/mv update
timeout_err  out  1  sticky conversion-timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n), sampled on the clk rising edge only.
- Reset values: all outputs 0. Accumulator, sample counter, timeout counter and synchronisers are cleared. The int_n synchroniser resets to 1, the wr_n delay register resets to 0, and the FSM resets to IDLE.
- Reset mid-operation: a partial accumulation is discarded and no mv_valid is produced.
- Input synchronisation:
  - int_n passes through a 2-flop synchroniser, then a third delay register for edge detect.
  - wr_n is registered once for rising-edge detect; it is internally generated, so no synchroniser.
  - db is sampled directly; it is stable while int_n is low.
- Capture latency:
  - Let E0 be the first clk edge that samples int_n low.
  - The falling edge is detected after E2.
  - sample <= db and sample_valid=1 take effect at E3, for exactly one cycle.
  - int_n must stay low for at least 4 cycles. A shorter low pulse that escapes detection is ignored.
- FSM states:
  - IDLE: wait for a wr_n rising edge, then go to CONVERT and clear the timeout counter.
  - CONVERT: count cycles.
    - If int_n fall is detected, go to CAPTURE.
    - If count reaches TIMEOUT-1 with no fall, set timeout_err and return to IDLE. The sample is discarded and the accumulator is untouched.
  - CAPTURE: one cycle. Load sample, pulse sample_valid, acc += sample, cnt++.
    - If cnt was 2^LOG2_AVG-1, go to AVERAGE.
    - Otherwise go to IDLE.
  - AVERAGE: avg <= acc[8+LOG2_AVG-1:LOG2_AVG] (truncating); clear acc and cnt; go to SCALE.
  - SCALE: mv <= (avg*VREF_MV)>>8 (truncating), computed at full product width; mv_valid=1 for one cycle; go to IDLE.
- mv_valid latency: asserts 2 cycles after the sample_valid of the final sample in a block.
- Simultaneous events:
  - A wr_n rising edge seen outside IDLE is ignored; the conversion is lost and counted by nobody.
  - err_clr and a new timeout in the same cycle: set wins.
- Widths: acc is 8+LOG2_AVG bits and cannot overflow. With LOG2_AVG=0, avg equals sample.

Optional Feature:
- Macro: ADC_PEAK_HOLD_EN.
- When defined:
  - Adds an output port peak (8 bits), reset 0.
  - On each CAPTURE, peak <= max(peak, db).
  - err_clr also clears peak to 0. If err_clr and a CAPTURE coincide, peak <= db.
- When undefined: no peak port and no comparator; all other behaviour is identical.

Decomposition:
- Shared package adc_pkg holds:
  - FSM state encoding (IDLE, CONVERT, CAPTURE, AVERAGE, SCALE).
  - ADC_DW=8.
  - Default VREF_MV.
- One natural sub-module: adc_edge_sync. It contains the 2-flop synchroniser plus delay register and outputs a fall pulse; it is reused by other ADC blocks.

Test Plan:
- Reset, then 8 conversions each returning db=0x80 -> eight sample_valid pulses with sample=0x80, then avg=0x80, mv=2500, one mv_valid.
- 8 conversions with db=0..7 -> avg=3 (28>>3), mv=58.
- 8 conversions with db=0xFF -> avg=0xFF, mv=4980.
- wr_n rising, int_n held high for 64 cycles -> timeout_err=1 and no sample_valid.
  - Next 8 good conversions still produce mv_valid.
  - err_clr pulse clears the flag.
- 5 conversions, assert reset_n low for 1 cycle, then 8 conversions of 0x40 -> exactly one mv_valid, avg=0x40, mv=1250.
- ADC_PEAK_HOLD_EN: samples 0x10, 0xC3, 0x22 -> peak=0xC3; err_clr -> peak=0.
